burst_master: RTL and testbench
===============================

BURST_MASTER -- requirements
Module: burst_master

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum idle cycles allowed while waiting for any slave handshake.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  user requests a burst.
REQ-005 cmd_ready  output  1  block is idle and accepts the command this cycle.
REQ-006 cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-007 cmd_addr / cmd_len / cmd_id  input  8 / 4 / 4  start address, beats minus one, transaction ID.
REQ-008 wd_valid / wd_ready / wd_data  input / output / input  1 / 1 / 8  user write-data stream.
REQ-009 rd_valid / rd_data / rd_err / rd_last  output  1 / 8 / 1 / 1  read-data stream to user, one-cycle pulse per beat.
REQ-010 done / done_err / done_id / done_timeout  output  1 / 1 / 4 / 1  one-cycle completion pulse with sticky status.
REQ-011 ARVALID, ARREADY(in), IN[15:0] = {addr, len, id}; RVALID(in), RREADY, RLAST(in), OUT(in)[8:0] = {data, err}.
REQ-012 AWVALID, AWREADY(in), AWIN[11:0] = {addr, id}; WVALID, WREADY(in), WLAST, WDATA[7:0]; BVALID(in), BREADY, BRESP(in)[4:0] = {err, id}.

Function
REQ-013 States: IDLE, AR, RD, AW, W, B, DONE; one transaction outstanding at a time.
REQ-014 IDLE: cmd_ready=1; on cmd_valid latch addr/len/id/write, go to AR (read) or AW (write).
REQ-015 AR: ARVALID=1 and IN driven from latched fields until ARREADY=1; then ARVALID=0 next cycle and go to RD.
REQ-016 RD: RREADY=1; each cycle RVALID=1, pass OUT[8:1] to rd_data, OUT[0] to rd_err, pulse rd_valid, increment beat counter.
REQ-017 RD ends on the beat where RLAST=1 or beat counter reaches len+1, whichever first; go to DONE.
REQ-018 AW: AWVALID=1 with AWIN until AWREADY=1; then AWVALID=0 and go to W.
REQ-019 W: WVALID mirrors wd_valid, wd_ready = WREADY; a beat transfers when WVALID and WREADY are both 1.
REQ-020 WLAST=1 exactly while presenting beat number len (0-based); after that beat transfers, deassert WVALID/WLAST and go to B.
REQ-021 B: BREADY=1 until BVALID=1; capture BRESP[4] into error, compare BRESP[3:0] with latched id (mismatch sets error); go to DONE.
REQ-022 DONE: one cycle, done=1 with done_id, done_err (sticky OR of all rd_err, BRESP errors, ID mismatch, timeout), done_timeout; return to IDLE.
REQ-023 Timeout counter clears on every handshake or beat; in AR/RD/AW/W/B reaching TIMEOUT forces DONE with done_timeout=1, done_err=1, all slave-side valids dropped.
REQ-024 Beat counter 5 bits, so len=15 yields 16 beats with no overflow; address is not incremented by the master (slave owns addressing).
REQ-025 cmd_valid outside IDLE is ignored; cmd_ready=0 in every non-IDLE state.
REQ-026 Write with len=0: the single beat carries WLAST=1.

Reset
REQ-027 rst=1 forces IDLE immediately, clears counters and status, drives all outputs to 0 except cmd_ready, which becomes 1 after release.
REQ-028 Reset mid-burst abandons the transaction without a done pulse.

Structure
REQ-029 Shared package holds the state enumeration, field widths (ADDR_W=8, LEN_W=4, ID_W=4, DATA_W=8), and the IN/AWIN/BRESP/OUT bit-field positions.
REQ-030 One sub-module, burst_timer, implements the clearable timeout counter; all else stays in burst_master.

Verification
REQ-031 Read: addr=0x10, len=3, id=5 with the slave preloaded with 1,2,3,4 -> IN=0x1035, four rd_valid pulses with data 1..4, rd_last on the 4th beat, done_err=0, done_id=5.
REQ-032 Write: addr=0x20, len=1, id=9, data 0xAA,0xBB -> AWIN=0x209, WLAST only on 0xBB, BRESP=0x09, done_err=0.
REQ-033 Read at addr=0xFE, len=3 -> beats 3 and 4 report rd_err=1, done_err=1.
REQ-034 Slave never asserts ARREADY -> after TIMEOUT cycles done=1, done_timeout=1, ARVALID=0.
REQ-035 rst pulse during W beat 2 of a len=7 write -> all outputs 0 and IDLE next cycle, no done pulse, and the next command is accepted normally.
REQ-036 wd_valid gaps during a write burst -> WVALID follows wd_valid, beat count is unaffected, WLAST still appears on beat len only.

Source files
------------

// File: rtl/burst_master_pkg.sv
// Shared definitions for the burst master: state encoding, field widths and
// bit positions of the packed slave-side buses.
package burst_master_pkg;

  localparam int ADDR_W = 8;
  localparam int LEN_W  = 4;
  localparam int ID_W   = 4;
  localparam int DATA_W = 8;
  localparam int BEAT_W = LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_RD,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  // IN = {addr, len, id}
  localparam int IN_W        = ADDR_W + LEN_W + ID_W;
  localparam int IN_ID_LSB   = 0;
  localparam int IN_LEN_LSB  = ID_W;
  localparam int IN_ADDR_LSB = ID_W + LEN_W;

  // AWIN = {addr, id}
  localparam int AWIN_W        = ADDR_W + ID_W;
  localparam int AWIN_ID_LSB   = 0;
  localparam int AWIN_ADDR_LSB = ID_W;

  // OUT = {data, err}
  localparam int OUT_W        = DATA_W + 1;
  localparam int OUT_ERR_BIT  = 0;
  localparam int OUT_DATA_LSB = 1;

  // BRESP = {err, id}
  localparam int BRESP_W       = ID_W + 1;
  localparam int BRESP_ID_LSB  = 0;
  localparam int BRESP_ERR_BIT = ID_W;

endpackage

// File: rtl/burst_timer.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// when the count reaches TIMEOUT.
module burst_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  // Saturates at LIMIT so a stalled owner never sees the flag wrap away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/burst_master.sv
// Single-outstanding burst master: takes one user command, runs the read
// (AR/RD) or write (AW/W/B) handshakes against the slave, then pulses done.
module burst_master
  import burst_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [ID_W-1:0]    cmd_id,
  input  logic               wd_valid,
  output logic               wd_ready,
  input  logic [DATA_W-1:0]  wd_data,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_err,
  output logic               rd_last,
  output logic               done,
  output logic               done_err,
  output logic [ID_W-1:0]    done_id,
  output logic               done_timeout,
  output logic               ARVALID,
  input  logic               ARREADY,
  output logic [IN_W-1:0]    IN,
  input  logic               RVALID,
  output logic               RREADY,
  input  logic               RLAST,
  input  logic [OUT_W-1:0]   OUT,
  output logic               AWVALID,
  input  logic               AWREADY,
  output logic [AWIN_W-1:0]  AWIN,
  output logic               WVALID,
  input  logic               WREADY,
  output logic               WLAST,
  output logic [DATA_W-1:0]  WDATA,
  input  logic               BVALID,
  output logic               BREADY,
  input  logic [BRESP_W-1:0] BRESP
);

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [LEN_W-1:0]    len;
  logic [ID_W-1:0]     id;
  logic [BEAT_W-1:0]   beat;
  logic                err;
  logic                w_phase;
  logic                hs;
  logic                active;
  logic                expired;
  logic                timed_out;
  logic                last_beat;
  logic                bresp_bad;

  assign IN        = {addr, len, id};
  assign AWIN      = {addr, id};
  assign last_beat = (beat == {1'b0, len});
  assign bresp_bad = BRESP[BRESP_ERR_BIT] || (BRESP[BRESP_ID_LSB +: ID_W] != id);

  // The write channel is a qualified pass-through of the user stream so no
  // data has to be buffered inside the master.
  assign WVALID   = w_phase && wd_valid;
  assign wd_ready = w_phase && WREADY;
  assign WLAST    = WVALID && last_beat;
  assign WDATA    = w_phase ? wd_data : '0;

  assign active = (state == S_AR) || (state == S_RD) || (state == S_AW) ||
                  (state == S_W)  || (state == S_B);

  always_comb begin
    // NOTE: the default assignment keeps this block free of inferred latches.
    hs = 1'b0;
    case (state)
      S_AR:    hs = ARREADY;
      S_RD:    hs = RVALID;
      S_AW:    hs = AWREADY;
      S_W:     hs = WVALID && WREADY;
      S_B:     hs = BVALID;
      default: hs = 1'b0;
    endcase
  end

  // A handshake landing on the expiry cycle still wins over the watchdog.
  assign timed_out = expired && !hs;

  burst_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (active),
    .clear   (hs),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cmd_ready    <= 1'b0;
      addr         <= '0;
      len          <= '0;
      id           <= '0;
      beat         <= '0;
      err          <= 1'b0;
      w_phase      <= 1'b0;
      ARVALID      <= 1'b0;
      RREADY       <= 1'b0;
      AWVALID      <= 1'b0;
      BREADY       <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_err       <= 1'b0;
      rd_last      <= 1'b0;
      done         <= 1'b0;
      done_err     <= 1'b0;
      done_id      <= '0;
      done_timeout <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments; later ones override these pulse defaults.
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
      if (timed_out) begin
        ARVALID      <= 1'b0;
        AWVALID      <= 1'b0;
        RREADY       <= 1'b0;
        BREADY       <= 1'b0;
        w_phase      <= 1'b0;
        state        <= S_DONE;
        done         <= 1'b1;
        done_err     <= 1'b1;
        done_timeout <= 1'b1;
        done_id      <= id;
      end else begin
        case (state)
          S_IDLE: begin
            cmd_ready <= 1'b1;
            if (cmd_valid && cmd_ready) begin
              cmd_ready    <= 1'b0;
              addr         <= cmd_addr;
              len          <= cmd_len;
              id           <= cmd_id;
              beat         <= '0;
              err          <= 1'b0;
              done_err     <= 1'b0;
              done_id      <= '0;
              done_timeout <= 1'b0;
              if (cmd_write) begin
                AWVALID <= 1'b1;
                state   <= S_AW;
              end else begin
                ARVALID <= 1'b1;
                state   <= S_AR;
              end
            end
          end
          S_AR: if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= S_RD;
          end
          S_RD: if (RVALID) begin
            rd_valid <= 1'b1;
            rd_data  <= OUT[OUT_DATA_LSB +: DATA_W];
            rd_err   <= OUT[OUT_ERR_BIT];
            err      <= err || OUT[OUT_ERR_BIT];
            beat     <= beat + 1'b1;
            if (RLAST || last_beat) begin
              rd_last  <= 1'b1;
              RREADY   <= 1'b0;
              done     <= 1'b1;
              done_id  <= id;
              done_err <= err || OUT[OUT_ERR_BIT];
              state    <= S_DONE;
            end
          end
          S_AW: if (AWREADY) begin
            AWVALID <= 1'b0;
            w_phase <= 1'b1;
            state   <= S_W;
          end
          S_W: if (WVALID && WREADY) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              w_phase <= 1'b0;
              BREADY  <= 1'b1;
              state   <= S_B;
            end
          end
          S_B: if (BVALID) begin
            BREADY   <= 1'b0;
            err      <= err || bresp_bad;
            done     <= 1'b1;
            done_id  <= id;
            done_err <= err || bresp_bad;
            state    <= S_DONE;
          end
          S_DONE: begin
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_burst_master.sv
// Scoreboard bench for burst_master: a behavioural slave pushes expected beats
// and completions into queues that are popped when the DUT reports them.
module tb_burst_master;

  localparam int unsigned TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [3:0]  cmd_len, cmd_id;
  logic        wd_valid, wd_ready;
  logic [7:0]  wd_data;
  logic        rd_valid, rd_err, rd_last;
  logic [7:0]  rd_data;
  logic        done, done_err, done_timeout;
  logic [3:0]  done_id;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [15:0] IN;
  logic [8:0]  OUT;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [11:0] AWIN;
  logic [7:0]  WDATA;
  logic [4:0]  BRESP;

  burst_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .rd_last(rd_last),
    .done(done), .done_err(done_err), .done_id(done_id), .done_timeout(done_timeout),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .IN(IN),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .OUT(OUT),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWIN(AWIN),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] data; logic err; logic last;} rd_exp_t;
  typedef struct packed {logic [3:0] id; logic err; logic to;} done_exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rd_exp_t   rd_q[$];
  done_exp_t done_q[$];
  logic [7:0] wq[$];
  logic [7:0] mem [256];

  // command / slave configuration
  bit         cmd_pend, spam, spam_on;
  bit         c_wr;
  logic [7:0] c_addr;
  logic [3:0] c_len, c_id;
  logic [15:0] exp_in;
  logic [11:0] exp_awin;
  bit         ar_accept, ar_seen, aw_seen;
  int         ar_first_cyc, done_cyc;
  logic [7:0] r_addr;
  logic [3:0] r_len;
  int         r_beat, r_last_at;
  bit         w_active, w_now, w_gaps;
  int         w_beat;
  logic [3:0] w_len;
  bit         b_err;
  logic [3:0] b_id;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({cmd_ready, ARVALID, IN, RREADY, AWVALID, AWIN, WVALID, WLAST, WDATA,
                BREADY, wd_ready, rd_valid, rd_data, rd_err, rd_last,
                done, done_err, done_id, done_timeout});
  endfunction

  // One clock: drive slave/user inputs after the falling edge, then sample.
  task automatic step();
    logic [8:0] ea;
    logic       e_err, e_last;
    logic [7:0] e_data;
    rd_exp_t    re;
    done_exp_t  de;
    @(negedge clk);
    cyc++;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; OUT = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = '0;
    wd_valid = 1'b0; wd_data = '0;
    spam_on = 1'b0;
    if (cmd_pend) begin
      cmd_valid = 1'b1; cmd_write = c_wr; cmd_addr = c_addr; cmd_len = c_len; cmd_id = c_id;
    end else if (spam && done_q.size() != 0) begin
      cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = 8'($urandom);
      cmd_len = 4'($urandom); cmd_id = 4'($urandom); spam_on = 1'b1;
    end
    w_now = w_active;
    if (w_active) begin
      WREADY   = w_gaps ? (cyc % 4 != 2) : 1'b1;
      wd_valid = (wq.size() != 0) && (w_gaps ? (cyc % 3 != 1) : 1'b1);
      wd_data  = (wq.size() != 0) ? wq[0] : 8'h00;
    end
    if (ARVALID) begin
      if (!ar_seen) begin
        check("ar_in", IN, exp_in);
        ar_seen = 1'b1;
        ar_first_cyc = cyc;
      end
      if (ar_accept) begin
        ARREADY = 1'b1; r_addr = IN[15:8]; r_len = IN[7:4]; r_beat = 0;
      end
    end
    if (RREADY) begin
      ea     = {1'b0, r_addr} + 9'(r_beat);
      e_err  = ea[8];
      e_data = e_err ? 8'h00 : mem[ea[7:0]];
      e_last = (r_beat == r_last_at) || (r_beat == int'(r_len));
      RVALID = 1'b1; OUT = {e_data, e_err}; RLAST = (r_beat == r_last_at);
      rd_q.push_back('{data: e_data, err: e_err, last: e_last});
      r_beat++;
    end
    if (AWVALID) begin
      if (!aw_seen) begin
        check("awin", AWIN, exp_awin);
        aw_seen = 1'b1;
      end
      AWREADY = 1'b1;
      w_active = 1'b1;
    end
    if (BREADY) begin
      BVALID = 1'b1; BRESP = {b_err, b_id};
    end
    #1;
    if (cmd_pend && cmd_ready) cmd_pend = 1'b0;
    if (spam_on) check("busy_cmd_ready", cmd_ready, 1'b0);
    if (w_now) begin
      check("wvalid_mirror", WVALID, wd_valid);
      check("wd_ready_mirror", wd_ready, WREADY);
      if (WVALID) check("wlast", WLAST, w_beat == int'(w_len));
      if (WVALID && WREADY) begin
        check("wdata", WDATA, wq.pop_front());
        if (w_beat == int'(w_len)) w_active = 1'b0;
        w_beat++;
      end
    end
    if (rd_valid) begin
      if (rd_q.size() == 0) check("unexpected_rd_valid", 1, 0);
      else begin
        re = rd_q.pop_front();
        check("rd_data", rd_data, re.data);
        check("rd_err", rd_err, re.err);
        check("rd_last", rd_last, re.last);
      end
    end
    if (done) begin
      done_cyc = cyc;
      check("done_valids_low", {ARVALID, AWVALID, WVALID, RREADY, BREADY}, 0);
      if (done_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        de = done_q.pop_front();
        check("done_id", done_id, de.id);
        check("done_err", done_err, de.err);
        check("done_timeout", done_timeout, de.to);
      end
    end
  endtask

  task automatic issue(input bit wr, input logic [7:0] a, input logic [3:0] l,
                       input logic [3:0] i, input bit e_err, input bit e_to);
    int g;
    c_wr = wr; c_addr = a; c_len = l; c_id = i; cmd_pend = 1'b1;
    exp_in = {a, l, i}; exp_awin = {a, i};
    ar_seen = 1'b0; aw_seen = 1'b0; w_beat = 0; w_len = l;
    done_q.push_back('{id: i, err: e_err, to: e_to});
    g = 0;
    while (cmd_pend && g < 50) begin step(); g++; end
    if (cmd_pend) begin
      check("cmd_accept_budget", 0, 1);
      cmd_pend = 1'b0;
    end
  endtask

  task automatic run_to_done(input int budget);
    int g;
    g = 0;
    while (done_q.size() != 0 && g < budget) begin step(); g++; end
    if (done_q.size() != 0) begin
      check("done_budget", 0, 1);
      done_q.delete();
    end
    check("rd_beats_left", rd_q.size(), 0);
    rd_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int g;
    rst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
    wd_valid = 0; wd_data = 0;
    ARREADY = 0; RVALID = 0; RLAST = 0; OUT = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    cmd_pend = 0; spam = 0; ar_accept = 1; r_last_at = 99;
    w_active = 0; w_gaps = 0; b_err = 0; b_id = 0;
    for (int k = 0; k < 256; k++) mem[k] = 8'(k * 7 + 3);
    mem[8'h10] = 8'd1; mem[8'h11] = 8'd2; mem[8'h12] = 8'd3; mem[8'h13] = 8'd4;

    repeat (2) @(posedge clk);
    #1 check("reset_outputs", outs(), 0);
    @(negedge clk) rst = 1'b0;

    // Read addr 0x10 len 3 id 5: data 1..4, last on beat 4
    issue(1'b0, 8'h10, 4'd3, 4'd5, 1'b0, 1'b0);
    check("ar_in_value", exp_in, 16'h1035);
    run_to_done(100);

    // Write addr 0x20 len 1 id 9 with AA, BB; busy-time commands must be ignored
    wq = '{8'hAA, 8'hBB}; b_id = 4'h9; b_err = 1'b0; spam = 1'b1;
    issue(1'b1, 8'h20, 4'd1, 4'd9, 1'b0, 1'b0);
    run_to_done(100);
    spam = 1'b0;

    // Single-beat write with BRESP id mismatch
    wq = '{8'h5C}; b_id = 4'h3;
    issue(1'b1, 8'h44, 4'd0, 4'd6, 1'b1, 1'b0);
    run_to_done(100);

    // Write with BRESP error bit
    wq = '{8'h01, 8'h02, 8'h03}; b_id = 4'h2; b_err = 1'b1;
    issue(1'b1, 8'h50, 4'd2, 4'd2, 1'b1, 1'b0);
    run_to_done(100);
    b_err = 1'b0;

    // Read crossing the top of the address space: beats 3 and 4 error
    issue(1'b0, 8'hFE, 4'd3, 4'd1, 1'b1, 1'b0);
    run_to_done(100);

    // Slave ends the read early with RLAST on beat 3 of 6
    r_last_at = 2;
    issue(1'b0, 8'h30, 4'd5, 4'd7, 1'b0, 1'b0);
    run_to_done(100);
    r_last_at = 99;

    // Maximum length read: 16 beats
    issue(1'b0, 8'h40, 4'd15, 4'hE, 1'b0, 1'b0);
    run_to_done(100);

    // ARREADY never comes: watchdog ends the transaction
    ar_accept = 1'b0;
    issue(1'b0, 8'h60, 4'd2, 4'hB, 1'b1, 1'b1);
    run_to_done(100);
    check("timeout_latency_ok",
          (done_cyc - ar_first_cyc >= int'(TIMEOUT)) && (done_cyc - ar_first_cyc <= int'(TIMEOUT) + 2), 1);
    ar_accept = 1'b1;

    // Write with user-side gaps and slave WREADY stalls
    wq = '{8'h10, 8'h20, 8'h30, 8'h40}; b_id = 4'h4; w_gaps = 1'b1;
    issue(1'b1, 8'h70, 4'd3, 4'd4, 1'b0, 1'b0);
    run_to_done(100);
    w_gaps = 1'b0;

    // Reset in the middle of a len=7 write: abandon without done
    wq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7}; b_id = 4'h8;
    issue(1'b1, 8'h80, 4'd7, 4'd8, 1'b0, 1'b0);
    g = 0;
    while (w_beat < 2 && g < 50) begin step(); g++; end
    check("reached_beat_2", w_beat, 2);
    rst = 1'b1;
    #1 check("midburst_reset_outputs", outs(), 0);
    done_q.delete(); rd_q.delete(); wq.delete(); w_active = 1'b0;
    @(negedge clk) rst = 1'b0;
    step();
    check("ready_after_reset", cmd_ready, 1'b1);
    repeat (4) step();

    // Next command after the abandoned one completes normally
    issue(1'b0, 8'h10, 4'd0, 4'hC, 1'b0, 1'b0);
    run_to_done(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
